ws2812_frame_ctrl: RTL and testbench

- Frame scheduler for the LED strip output.
- On `start`, reads N_LEDS 24-bit GRB words from the pixel RAM (1-cycle registered read) and serialises each word MSB-first onto `dout` with WS2812 high/low bit timing.
- Prefetches the next word so there is no gap between pixels, then holds `dout` low for the latch/reset period and pulses `done`.
- Sits between the pixel frame buffer and the strip data pin.

---
 rtl/ws2812_frame_ctrl_if.sv | 20 ++
 rtl/ws2812_frame_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_frame_ctrl_if.sv
// rtl/ws2812_frame_ctrl_if.sv - pixel RAM read port between frame controller (master) and frame buffer (slave)
interface ws2812_frame_ctrl_if #(
    parameter int AW = 6
);
    logic          pix_rd;
    logic [AW-1:0] pix_addr;
    logic [23:0]   pix_data;

    modport master (
        output pix_rd,
        output pix_addr,
        input  pix_data
    );

    modport slave (
        input  pix_rd,
        input  pix_addr,
        output pix_data
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - WS2812 frame scheduler: pixel RAM fetch/prefetch, bit serialiser, latch period
// Optional per-frame brightness scaling of every colour byte when WS2812_BRIGHTNESS_EN is defined.
module ws2812_frame_ctrl #(
    parameter int N_LEDS    = 64,
    parameter int T0H_CYC   = 16,
    parameter int T1H_CYC   = 32,
    parameter int TBIT_CYC  = 50,
    parameter int RESET_CYC = 2600,
    parameter int AW        = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]          brightness,
`endif
    ws2812_frame_ctrl_if.master pix,
    output logic                dout,
    output logic                busy,
    output logic                done
);
    localparam int CNT_MAX = (TBIT_CYC > RESET_CYC) ? TBIT_CYC : RESET_CYC;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [AW-1:0] LAST_LED   = AW'(N_LEDS - 1);
    localparam logic [CW-1:0] TBIT_LAST  = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYC - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYC);

    typedef enum logic [2:0] {IDLE, FETCH, BIT_HI, BIT_LO, LATCH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    bit_idx, bit_n;
    logic [AW-1:0] led_idx, led_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [23:0]   shift_word, shift_n;
    logic [23:0]   next_word, next_n;
    logic          rd_q, rd_n, rd_d;
    logic          dout_n, busy_n, done_n;
    logic [CW-1:0] th;
    logic [23:0]   captured;

`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] bright, bright_n;

    function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] b);
        logic [16:0] p;
        logic [23:0] r;
        for (int i = 0; i < 3; i++) begin
            p = 17'(w[8*i +: 8]) * 17'({1'b0, b} + 9'd1);
            r[8*i +: 8] = p[15:8];
        end
        return r;
    endfunction

    assign captured = scale_word(pix.pix_data, bright);
`else
    assign captured = pix.pix_data;
`endif

    assign pix.pix_rd   = rd_q;
    assign pix.pix_addr = addr_q;
    assign th           = shift_word[23] ? T1H : T0H;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        led_n   = led_idx;
        addr_n  = addr_q;
        shift_n = shift_word;
        next_n  = next_word;
        rd_n    = 1'b0;
        dout_n  = dout;
        busy_n  = busy;
        done_n  = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
        bright_n = bright;
`endif
        case (state)
            IDLE: begin
                dout_n = 1'b0;
                // The done cycle already shows IDLE, so a start there must be masked.
                if (start && !done) begin
                    busy_n  = 1'b1;
                    rd_n    = 1'b1;
                    addr_n  = '0;
                    led_n   = '0;
                    state_n = FETCH;
`ifdef WS2812_BRIGHTNESS_EN
                    bright_n = brightness;
`endif
                end
            end
            FETCH: begin
                if (rd_d) begin
                    shift_n = captured;
                    dout_n  = 1'b1;
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = BIT_HI;
                end
            end
            BIT_HI, BIT_LO: begin
                if (rd_d) next_n = captured;
                if (cnt == TBIT_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 5'd23) begin
                        if (led_idx == LAST_LED) begin
                            dout_n  = 1'b0;
                            state_n = LATCH;
                        end else begin
                            led_n   = led_idx + AW'(1);
                            shift_n = next_word;
                            bit_n   = '0;
                            dout_n  = 1'b1;
                            state_n = BIT_HI;
                        end
                    end else begin
                        shift_n = {shift_word[22:0], 1'b0};
                        bit_n   = bit_idx + 5'd1;
                        dout_n  = 1'b1;
                        state_n = BIT_HI;
                        // Entering bit 23: fetch the next pixel so it is ready at the word boundary.
                        if (bit_idx == 5'd22 && led_idx != LAST_LED) begin
                            rd_n   = 1'b1;
                            addr_n = led_idx + AW'(1);
                        end
                    end
                end else begin
                    cnt_n   = cnt + CW'(1);
                    dout_n  = (cnt + CW'(1)) < th;
                    state_n = dout_n ? BIT_HI : BIT_LO;
                end
            end
            LATCH: begin
                dout_n = 1'b0;
                if (cnt == RESET_LAST) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            led_idx    <= '0;
            addr_q     <= '0;
            shift_word <= '0;
            next_word  <= '0;
            rd_q       <= 1'b0;
            rd_d       <= 1'b0;
            dout       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
            bright     <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            led_idx    <= led_n;
            addr_q     <= addr_n;
            shift_word <= shift_n;
            next_word  <= next_n;
            rd_q       <= rd_n;
            rd_d       <= rd_q;
            dout       <= dout_n;
            busy       <= busy_n;
            done       <= done_n;
`ifdef WS2812_BRIGHTNESS_EN
            bright     <= bright_n;
`endif
        end
    end
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - randomized frame checks of ws2812_frame_ctrl against a waveform reference model
module tb_ws2812_frame_ctrl;
    localparam int N_LEDS = 2;
    localparam int T0H    = 2;
    localparam int T1H    = 5;
    localparam int TBIT   = 8;
    localparam int RST_C  = 20;
    localparam int AW     = 6;
    localparam int NBITS  = N_LEDS * 24 * TBIT;
    localparam int FRAME  = 2 + NBITS + RST_C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic dout, busy, done;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] brightness = 8'hFF;
`endif

    logic [23:0] ram   [0:(1<<AW)-1];
    logic [23:0] words [0:N_LEDS-1];
    int vectors = 0;
    int errors  = 0;

    ws2812_frame_ctrl_if #(.AW(AW)) pif ();

    ws2812_frame_ctrl #(
        .N_LEDS(N_LEDS), .T0H_CYC(T0H), .T1H_CYC(T1H),
        .TBIT_CYC(TBIT), .RESET_CYC(RST_C), .AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .pix(pif.master),
        .dout(dout),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Registered-read RAM; garbage on the bus whenever no read was issued.
    always @(posedge clk) begin
        if (pif.pix_rd) pif.pix_data <= ram[pif.pix_addr];
        else            pif.pix_data <= 24'($urandom);
    end

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        return 8'((int'(c) * (int'(b) + 1)) / 256);
    endfunction

    // Expected {dout, busy, done, pix_rd, addr-if-rd} at sample i (i edges after the start edge).
    function automatic logic [9:0] expect_at(input int i, input int rst_at);
        logic d, bz, dn, rd;
        logic [5:0] a;
        logic [23:0] w;
        int j, c, g;
        d = 1'b0; rd = 1'b0; a = 6'd0;
        if (rst_at >= 0 && i > rst_at) return 10'd0;
        if (i >= 2 && i < 2 + NBITS) begin
            j = i - 2;
            c = j % TBIT;
            g = j / TBIT;
            w = words[g / 24];
            d = (c < (w[23 - (g % 24)] ? T1H : T0H));
        end
        bz = (i < FRAME);
        dn = (i == FRAME);
        if (i == 0) rd = 1'b1;
        for (int k = 0; k < N_LEDS - 1; k++)
            if (i == 2 + (24 * k + 23) * TBIT) begin
                rd = 1'b1;
                a  = 6'(k + 1);
            end
        return {d, bz, dn, rd, a};
    endfunction

    task automatic run_frame(input string name, input int nsamp, input int extra_at, input int rst_at);
        logic [9:0] got, exp;
        for (int k = 0; k < N_LEDS; k++) begin
`ifdef WS2812_BRIGHTNESS_EN
            words[k] = {scale8(ram[k][23:16], brightness), scale8(ram[k][15:8], brightness),
                        scale8(ram[k][7:0], brightness)};
`else
            words[k] = ram[k];
`endif
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'($urandom);
`endif
        for (int i = 0; i < nsamp; i++) begin
            if (i > 0) begin
                start = (i - 1 == extra_at);
                rst   = (i - 1 == rst_at);
                @(posedge clk);
                #1;
            end
            got = {dout, busy, done, pif.pix_rd, pif.pix_rd ? pif.pix_addr : 6'd0};
            exp = expect_at(i, rst_at);
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: dout/busy/done/rd/addr got %b required %b", name, i, got, exp);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic randomize_ram();
        for (int k = 0; k < N_LEDS; k++) ram[k] = 24'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({dout, busy, done, pif.pix_rd, pif.pix_addr} !== 10'd0) begin
            errors++;
            $display("FAIL reset_values: got %b required %b", {dout, busy, done, pif.pix_rd, pif.pix_addr}, 10'd0);
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({dout, busy, done, pif.pix_rd} !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required %b", {dout, busy, done, pif.pix_rd}, 4'd0);
        end
    endtask

    task automatic test_basic_frame();
        ram[0] = 24'hE15F10;
        ram[1] = 24'h0000FF;
`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'hFF;
`endif
        run_frame("basic_frame", FRAME + 8, -1, -1);
    endtask

    task automatic test_start_while_busy();
        randomize_ram();
        run_frame("start_while_busy", FRAME + 6, 100, -1);
    endtask

    task automatic test_done_cycle_start();
        randomize_ram();
        run_frame("done_cycle_start", FRAME + 10, FRAME, -1);
    endtask

    task automatic test_back_to_back();
        randomize_ram();
        run_frame("b2b_first", FRAME + 2, -1, -1);
        randomize_ram();
        run_frame("b2b_second", FRAME + 4, -1, -1);
    endtask

    task automatic test_reset_mid_frame();
        randomize_ram();
        run_frame("mid_reset", 160, -1, 150);
        run_frame("replay_after_reset", FRAME + 4, -1, -1);
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 4; n++) begin
            randomize_ram();
            if (n == 0) for (int k = 0; k < N_LEDS; k++) ram[k] = 24'h000000;
            if (n == 1) for (int k = 0; k < N_LEDS; k++) ram[k] = 24'hFFFFFF;
`ifdef WS2812_BRIGHTNESS_EN
            brightness = 8'($urandom);
            if (n == 2) brightness = 8'h00;
`endif
            run_frame("random_frame", FRAME + 3, -1, -1);
        end
    endtask

`ifdef WS2812_BRIGHTNESS_EN
    task automatic test_brightness();
        ram[0] = 24'hFF8002;
        ram[1] = 24'($urandom);
        brightness = 8'h7F;
        run_frame("brightness_7f", FRAME + 2, -1, -1);
        ram[0] = 24'hFF8002;
        brightness = 8'hFF;
        run_frame("brightness_ff", FRAME + 2, -1, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_start_while_busy();
        test_done_cycle_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
`ifdef WS2812_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
